config_bus_driver: RTL and testbench



---
 rtl/config_bus_driver.sv | 171 +++++++++++++++++
 tb/tb_config_bus_driver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/config_bus_driver.sv
// Config-bus master: turns one valid/ready request into a single config_read/config_write
// transaction and returns captured read data on a valid/ready response channel.
module config_bus_driver #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int READ_WAIT  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] config_config_addr,
    output logic [DATA_WIDTH-1:0] config_config_data,
    output logic                  config_read,
    output logic                  config_write,
    input  logic [DATA_WIDTH-1:0] read_config_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [3:0] WAIT_LOAD = 4'(READ_WAIT);

    state_e                  state_q, state_d;
    logic                    op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic                    req_ready_q, req_ready_d;
    logic                    busy_q, busy_d;
    logic                    cfg_read_q, cfg_read_d;
    logic                    cfg_write_q, cfg_write_d;
    logic                    rsp_valid_q, rsp_valid_d;

    // Next-state and datapath: fields are sampled only at the accept edge in IDLE
    always_comb begin
        state_d    = state_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_write_d = req_write;
                    addr_d     = req_addr;
                    data_d     = req_data;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (op_write_q) begin
                    state_d = ST_IDLE;
                end else if (WAIT_LOAD == 4'd0) begin
                    rsp_data_d = read_config_data;
                    state_d    = ST_RESP;
                end else begin
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A count of 1 (or a corrupted 0) ends the wait so the FSM can never stall here
                if (wait_cnt_q <= 4'd1) begin
                    wait_cnt_d = 4'd0;
                    rsp_data_d = read_config_data;
                    state_d    = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                    state_d    = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    // Output decode from the next state so every output port comes straight off a flop
    always_comb begin
        req_ready_d = 1'b0;
        busy_d      = 1'b1;
        cfg_read_d  = 1'b0;
        cfg_write_d = 1'b0;
        rsp_valid_d = 1'b0;
        case (state_d)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            ST_ISSUE: begin
                if (op_write_d) begin
                    cfg_write_d = 1'b1;
                end else begin
                    cfg_read_d = 1'b1;
                end
            end
            ST_WAIT: begin
                cfg_read_d = 1'b1;
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_write_q  <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            wait_cnt_q  <= 4'd0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            cfg_read_q  <= 1'b0;
            cfg_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_write_q  <= op_write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            wait_cnt_q  <= wait_cnt_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            cfg_read_q  <= cfg_read_d;
            cfg_write_q <= cfg_write_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready          = req_ready_q;
    assign busy               = busy_q;
    assign config_read        = cfg_read_q;
    assign config_write       = cfg_write_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_data           = rsp_data_q;
    assign config_config_addr = addr_q;
    assign config_config_data = data_q;

endmodule

// File: tb/tb_config_bus_driver.sv
// Directed bench: instance 0 uses READ_WAIT=0, instance 1 uses READ_WAIT=3; each
// drives a small register-file model of the core.
module tb_config_bus_driver;

    logic        clk;
    logic [1:0]  reset;
    logic [1:0]  req_valid, req_ready, req_write;
    logic [7:0]  req_addr [2];
    logic [31:0] req_data [2];
    logic [1:0]  rsp_valid, rsp_ready;
    logic [31:0] rsp_data [2];
    logic [7:0]  cfg_addr [2];
    logic [31:0] cfg_data [2];
    logic [1:0]  cfg_read, cfg_write, busy;
    logic [31:0] rcd [2];
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];

    int checks = 0;
    int failures = 0;
    int excl_viol = 0;
    int rsp_seen;

    config_bus_driver #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_data(req_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .config_config_addr(cfg_addr[0]), .config_config_data(cfg_data[0]),
        .config_read(cfg_read[0]), .config_write(cfg_write[0]),
        .read_config_data(rcd[0]), .busy(busy[0])
    );

    config_bus_driver #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_WAIT(3)) u_dut1 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_data(req_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .config_config_addr(cfg_addr[1]), .config_config_data(cfg_data[1]),
        .config_read(cfg_read[1]), .config_write(cfg_write[1]),
        .read_config_data(rcd[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: registers written on the strobe, read data a function of the address
    always @(posedge clk) begin
        if (cfg_write[0]) mem0[cfg_addr[0]] <= cfg_data[0];
        if (cfg_write[1]) mem1[cfg_addr[1]] <= cfg_data[1];
    end
    assign rcd[0] = mem0[cfg_addr[0]];
    assign rcd[1] = mem1[cfg_addr[1]];

    always @(negedge clk) begin
        if (cfg_read[0] && cfg_write[0]) excl_viol++;
        if (cfg_read[1] && cfg_write[1]) excl_viol++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input int s);
        check("rst_req_ready", req_ready[s], 1);
        check("rst_busy", busy[s], 0);
        check("rst_cfg_read", cfg_read[s], 0);
        check("rst_cfg_write", cfg_write[s], 0);
        check("rst_rsp_valid", rsp_valid[s], 0);
        check("rst_cfg_addr", cfg_addr[s], 0);
        check("rst_cfg_data", cfg_data[s], 0);
        check("rst_rsp_data", rsp_data[s], 0);
    endtask

    task automatic do_write(input int s, input logic [7:0] a, input logic [31:0] d);
        req_valid[s] = 1'b1; req_write[s] = 1'b1; req_addr[s] = a; req_data[s] = d;
        tick();
        req_valid[s] = 1'b0;
        check("wr_strobe", cfg_write[s], 1);
        check("wr_no_read", cfg_read[s], 0);
        check("wr_addr", cfg_addr[s], a);
        check("wr_data", cfg_data[s], d);
        check("wr_ready_low", req_ready[s], 0);
        check("wr_busy", busy[s], 1);
        tick();
        check("wr_strobe_drop", cfg_write[s], 0);
        check("wr_ready_back", req_ready[s], 1);
        check("wr_no_rsp", rsp_valid[s], 0);
        check("wr_addr_hold", cfg_addr[s], a);
    endtask

    // bp = number of extra cycles rsp_ready is held low while the response is shown
    task automatic do_read(input int s, input logic [7:0] a, input logic [31:0] exp,
                           input int wait_n, input int bp);
        rsp_ready[s] = (bp == 0);
        req_valid[s] = 1'b1; req_write[s] = 1'b0; req_addr[s] = a; req_data[s] = 32'h0;
        tick();
        req_valid[s] = 1'b0;
        for (int i = 0; i <= wait_n; i++) begin
            if (i > 0) tick();
            check("rd_strobe", cfg_read[s], 1);
            check("rd_no_write", cfg_write[s], 0);
            check("rd_addr", cfg_addr[s], a);
            check("rd_no_rsp_yet", rsp_valid[s], 0);
        end
        tick();
        check("rd_rsp_valid", rsp_valid[s], 1);
        check("rd_rsp_data", rsp_data[s], exp);
        check("rd_strobe_drop", cfg_read[s], 0);
        check("rd_ready_low", req_ready[s], 0);
        for (int i = 0; i < bp; i++) begin
            req_valid[s] = 1'b1; req_write[s] = 1'b1; req_addr[s] = 8'hAA; req_data[s] = 32'h5555_AAAA;
            tick();
            check("bp_rsp_valid", rsp_valid[s], 1);
            check("bp_rsp_data", rsp_data[s], exp);
            check("bp_ready_low", req_ready[s], 0);
            check("bp_addr_hold", cfg_addr[s], a);
            check("bp_no_write", cfg_write[s], 0);
        end
        req_valid[s] = 1'b0;
        rsp_ready[s] = 1'b1;
        tick();
        check("hs_rsp_drop", rsp_valid[s], 0);
        check("hs_ready_back", req_ready[s], 1);
        check("hs_busy_low", busy[s], 0);
    endtask

    initial begin
        reset = 2'b11; req_valid = 2'b00; req_write = 2'b00; rsp_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            req_addr[i] = 8'h00;
            req_data[i] = 32'h0;
        end
        tick();
        tick();
        reset = 2'b00;
        check_reset(0);
        check_reset(1);

        // READ_WAIT = 0 instance
        do_write(0, 8'h01, 32'hDEAD_BEEF);
        do_read(0, 8'h01, 32'hDEAD_BEEF, 0, 0);
        do_write(0, 8'h00, 32'h1234_5678);
        do_read(0, 8'h00, 32'h1234_5678, 0, 0);
        do_read(0, 8'h01, 32'hDEAD_BEEF, 0, 5);
        do_write(0, 8'hFF, 32'hA5A5_5A5A);
        do_read(0, 8'hFF, 32'hA5A5_5A5A, 0, 0);
        reset[0] = 1'b1;
        tick();
        reset[0] = 1'b0;
        check_reset(0);

        // READ_WAIT = 3 instance
        do_write(1, 8'h01, 32'hCAFE_F00D);
        do_read(1, 8'h01, 32'hCAFE_F00D, 3, 0);

        // Abort a read while waiting
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 8'h01;
        tick();
        req_valid[1] = 1'b0;
        check("ab_issue_read", cfg_read[1], 1);
        tick();
        check("ab_wait_read", cfg_read[1], 1);
        check("ab_wait_busy", busy[1], 1);
        reset[1] = 1'b1;
        tick();
        reset[1] = 1'b0;
        check("ab_read_drop", cfg_read[1], 0);
        check("ab_busy_low", busy[1], 0);
        check("ab_ready", req_ready[1], 1);
        check("ab_rsp_data", rsp_data[1], 0);
        rsp_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid[1]) rsp_seen++;
        end
        check("ab_no_rsp", rsp_seen, 0);
        do_write(1, 8'h02, 32'h0BAD_F00D);
        do_read(1, 8'h02, 32'h0BAD_F00D, 3, 2);

        check("strobe_excl", excl_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
